// File: rtl/blinkers_pkg.sv
// Shared constants and types for the blinker random-interval source.
// LFSR taps, default seed, interval width and generator state encoding.
package blinkers_pkg;

  localparam logic [15:0] LFSR16_TAPS  = 16'hB400;
  localparam logic [15:0] DEFAULT_SEED = 16'hACE1;
  localparam int          INTERVAL_W   = 4;

  typedef enum logic {
    SEARCH = 1'b0,
    VALID  = 1'b1
  } gen_state_t;

endpackage

// File: rtl/lfsr_core.sv
// Galois LFSR register with step enable, seed load and zero-seed guard.
// Exposes only the low OUT_W bits used as the draw candidate.
module lfsr_core
  import blinkers_pkg::*;
#(
  parameter int               LFSR_W = 16,
  parameter int               OUT_W  = INTERVAL_W,
  parameter logic [LFSR_W-1:0] SEED  = DEFAULT_SEED
) (
  input  logic              clk,
  input  logic              rstbtn,
  input  logic              step,
  input  logic              load,
  input  logic [LFSR_W-1:0] load_val,
  output logic [OUT_W-1:0]  low
);

  localparam logic [LFSR_W-1:0] TAPS = LFSR_W'(LFSR16_TAPS);

  logic [LFSR_W-1:0] lfsr;
  logic [LFSR_W-1:0] lfsr_nxt;

  assign lfsr_nxt = (lfsr >> 1) ^ (lfsr[0] ? TAPS : '0);
  assign low      = lfsr[OUT_W-1:0];

  // an all-zero state would lock the register, so zero loads take SEED
  always_ff @(posedge clk or posedge rstbtn) begin
    if (rstbtn) begin
      lfsr <= SEED;
    end else if (load) begin
      lfsr <= (load_val == '0) ? SEED : load_val;
    end else if (step) begin
      lfsr <= lfsr_nxt;
    end
  end

endmodule

// File: rtl/lfsr_interval_gen.sv
// Random blink interval via LFSR rejection sampling, valid/ready output.
// Define LFSR_STATS_EN to add saturating accept/reject counters.
module lfsr_interval_gen
  import blinkers_pkg::*;
#(
  parameter int               LFSR_W  = 16,
  parameter int               INT_W   = INTERVAL_W,
  parameter int               MIN_INT = 2,
  parameter int               MAX_INT = 12,
  parameter logic [LFSR_W-1:0] SEED   = DEFAULT_SEED
) (
  input  logic              clk,
  input  logic              rstbtn,
  input  logic              seed_load,
  input  logic [LFSR_W-1:0] seed_in,
  input  logic              interval_ready,
`ifdef LFSR_STATS_EN
  output logic [15:0]       stat_accepts,
  output logic [15:0]       stat_rejects,
`endif
  output logic              interval_valid,
  output logic [INT_W-1:0]  interval
);

  gen_state_t       state;
  logic [INT_W-1:0] cand;
  logic             acc;
  logic             step;

  assign acc  = (cand >= INT_W'(MIN_INT)) && (cand <= INT_W'(MAX_INT));
  assign step = (state == SEARCH) || (interval_valid && interval_ready);

  lfsr_core #(
    .LFSR_W (LFSR_W),
    .OUT_W  (INT_W),
    .SEED   (SEED)
  ) u_core (
    .clk      (clk),
    .rstbtn   (rstbtn),
    .step     (step),
    .load     (seed_load),
    .load_val (seed_in),
    .low      (cand)
  );

  always_ff @(posedge clk or posedge rstbtn) begin
    if (rstbtn) begin
      state          <= SEARCH;
      interval_valid <= 1'b0;
      interval       <= INT_W'(MIN_INT);
    end else if (seed_load) begin
      state          <= SEARCH;
      interval_valid <= 1'b0;
    end else begin
      unique case (state)
        SEARCH: begin
          if (acc) begin
            interval       <= cand;
            interval_valid <= 1'b1;
            state          <= VALID;
          end
        end
        VALID: begin
          // a completed transfer re-evaluates on the same edge: no bubble
          if (interval_ready) begin
            if (acc) begin
              interval <= cand;
            end else begin
              interval_valid <= 1'b0;
              state          <= SEARCH;
            end
          end
        end
        default: state <= SEARCH;
      endcase
    end
  end

`ifdef LFSR_STATS_EN
  logic eval;

  assign eval = step && !seed_load;

  always_ff @(posedge clk or posedge rstbtn) begin
    if (rstbtn) begin
      stat_accepts <= '0;
      stat_rejects <= '0;
    end else if (seed_load) begin
      stat_accepts <= '0;
      stat_rejects <= '0;
    end else if (eval) begin
      if (acc && stat_accepts != '1) begin
        stat_accepts <= stat_accepts + 16'd1;
      end
      if (!acc && stat_rejects != '1) begin
        stat_rejects <= stat_rejects + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_lfsr_interval_gen.sv
// Directed and model-checked bench for lfsr_interval_gen.
// Expected draws are hand-derived from the 0xB400 Galois sequence.
module tb_lfsr_interval_gen;

  logic        clk = 1'b0;
  logic        rstbtn = 1'b1;
  logic        seed_load = 1'b0;
  logic [15:0] seed_in = 16'h0;
  logic        interval_ready = 1'b0;
  logic        interval_valid;
  logic [3:0]  interval;
`ifdef LFSR_STATS_EN
  logic [15:0] stat_accepts;
  logic [15:0] stat_rejects;
`endif

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  lfsr_interval_gen u_dut (
    .clk            (clk),
    .rstbtn         (rstbtn),
    .seed_load      (seed_load),
    .seed_in        (seed_in),
    .interval_ready (interval_ready),
`ifdef LFSR_STATS_EN
    .stat_accepts   (stat_accepts),
    .stat_rejects   (stat_rejects),
`endif
    .interval_valid (interval_valid),
    .interval       (interval)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h want %0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [15:0] nxt(input logic [15:0] s);
    return (s >> 1) ^ (s[0] ? 16'hB400 : 16'h0);
  endfunction

  logic [15:0] m_lfsr;
  logic        m_valid;
  logic [3:0]  m_int;
  logic [3:0]  c;
  logic        a;
  logic        rdy;
  int          steps;

  initial begin
    // reset state
    #12;
    chk("rst_valid", 32'(interval_valid), 32'd0);
    chk("rst_int", 32'(interval), 32'd2);
    @(negedge clk);
    rstbtn = 1'b0;

    // candidates 1, 0 rejected; 8 accepted on edge 3
    tick();
    chk("e1_valid", 32'(interval_valid), 32'd0);
    tick();
    chk("e2_valid", 32'(interval_valid), 32'd0);
    tick();
    chk("e3_valid", 32'(interval_valid), 32'd1);
    chk("e3_int", 32'(interval), 32'd8);
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("hold_valid", 32'(interval_valid), 32'd1);
      chk("hold_int", 32'(interval), 32'd8);
    end

    // back-to-back 8, 12; 14 rejected; then 7
    interval_ready = 1'b1;
    tick();
    chk("b2b_valid", 32'(interval_valid), 32'd1);
    chk("b2b_int", 32'(interval), 32'd12);
    tick();
    chk("rej14_valid", 32'(interval_valid), 32'd0);
    tick();
    chk("draw7_valid", 32'(interval_valid), 32'd1);
    chk("draw7_int", 32'(interval), 32'd7);
    interval_ready = 1'b0;
    tick();

    // zero seed replays the default sequence
    seed_load = 1'b1;
    seed_in   = 16'h0000;
    tick();
    seed_load = 1'b0;
    chk("ld0_valid", 32'(interval_valid), 32'd0);
`ifdef LFSR_STATS_EN
    chk("ld0_acc", 32'(stat_accepts), 32'd0);
    chk("ld0_rej", 32'(stat_rejects), 32'd0);
`endif
    tick();
    tick();
    chk("rp_pre", 32'(interval_valid), 32'd0);
    tick();
    chk("rp8_valid", 32'(interval_valid), 32'd1);
    chk("rp8_int", 32'(interval), 32'd8);
    interval_ready = 1'b1;
    tick();
    chk("rp12_int", 32'(interval), 32'd12);
    tick();
    chk("rp_gap", 32'(interval_valid), 32'd0);
    tick();
    chk("rp7_valid", 32'(interval_valid), 32'd1);
    chk("rp7_int", 32'(interval), 32'd7);

    // seed load coincident with a transfer of 7
    seed_load = 1'b1;
    seed_in   = 16'h7138;
    chk("ldx_pre", 32'(interval), 32'd7);
    tick();
    seed_load = 1'b0;
    interval_ready = 1'b0;
    chk("ldx_valid", 32'(interval_valid), 32'd0);
    tick();
    chk("ldx_new_v", 32'(interval_valid), 32'd1);
    chk("ldx_new_i", 32'(interval), 32'd8);

    // async reset between edges
    #2;
    rstbtn = 1'b1;
    #1;
    chk("arst_valid", 32'(interval_valid), 32'd0);
    chk("arst_int", 32'(interval), 32'd2);
    @(negedge clk);
    rstbtn = 1'b0;
    tick();
    tick();
    chk("ar_pre", 32'(interval_valid), 32'd0);
    tick();
    chk("ar8_valid", 32'(interval_valid), 32'd1);
    chk("ar8_int", 32'(interval), 32'd8);

    // random ready against a reference model
    seed_load = 1'b1;
    seed_in   = 16'h1234;
    tick();
    seed_load = 1'b0;
    m_lfsr  = 16'h1234;
    m_valid = 1'b0;
    m_int   = 4'd8;
    steps   = 0;
    for (int i = 0; i < 10000; i++) begin
      rdy = 1'($urandom_range(0, 1));
      interval_ready = rdy;
      if (m_valid && rdy)
        chk("xfer_rng", 32'(interval >= 4'd2 && interval <= 4'd12), 32'd1);
      c = m_lfsr[3:0];
      a = (c >= 4'd2) && (c <= 4'd12);
      if (!m_valid || rdy) begin
        m_lfsr = nxt(m_lfsr);
        steps++;
      end
      if (!m_valid) begin
        if (a) begin
          m_valid = 1'b1;
          m_int   = c;
        end
      end else if (rdy) begin
        if (a) m_int = c;
        else   m_valid = 1'b0;
      end
      tick();
      chk("rnd_valid", 32'(interval_valid), 32'(m_valid));
      if (m_valid) chk("rnd_int", 32'(interval), 32'(m_int));
    end
    interval_ready = 1'b0;
`ifdef LFSR_STATS_EN
    chk("stat_sum", 32'(stat_accepts) + 32'(stat_rejects), 32'(steps));
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
